// File: rtl/exe_pkg.sv
// rtl/exe_pkg.sv - shared encodings for the execute stage
package exe_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MUL = 4'b1010;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam logic [1:0] FWD_REG     = 2'b00;
  localparam logic [1:0] FWD_ALU_MEM = 2'b01;
  localparam logic [1:0] FWD_WB      = 2'b10;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {ST_IDLE, ST_BUSY} exe_state_e;

endpackage

// File: rtl/val2_gen_p.sv
// rtl/val2_gen_p.sv - second-operand generator: address offset, rotated immediate or shifted register
module val2_gen_p import exe_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rm,
  input  logic [11:0]       shift_operand,
  input  logic              imm,
  input  logic              mem_en,
  output logic [DATA_W-1:0] val2
);

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input int unsigned amt);
    logic [2*DATA_W-1:0] d;
    d = {x, x} >> amt;
    return d[DATA_W-1:0];
  endfunction

  int unsigned rot_amt;
  int unsigned sh_amt;

  always_comb begin
    rot_amt = (32'(shift_operand[11:8]) << 1) % 32'(DATA_W);
    sh_amt  = 32'(shift_operand[11:7]) % 32'(DATA_W);
    if (mem_en) begin
      val2 = DATA_W'(shift_operand[11:0]);
    end else if (imm) begin
      val2 = rotr(DATA_W'(shift_operand[7:0]), rot_amt);
    end else begin
      case (shift_operand[6:5])
        SH_LSL:  val2 = rm << sh_amt;
        SH_LSR:  val2 = rm >> sh_amt;
        SH_ASR:  val2 = $unsigned($signed(rm) >>> sh_amt);
        SH_ROR:  val2 = rotr(rm, sh_amt);
        default: val2 = rm;
      endcase
    end
  end

endmodule

// File: rtl/exe_stage_pipe.sv
// rtl/exe_stage_pipe.sv - registered execute stage: forwarding, ALU, iterative MUL, branch target
module exe_stage_pipe import exe_pkg::*; #(
  parameter int DATA_W  = 32,
  parameter int MUL_BPC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        exe_cmd,
  input  logic              imm,
  input  logic              sr,
  input  logic [3:0]        flags_in,
  input  logic [6:0]        ctl_in,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] val_rn,
  input  logic [DATA_W-1:0] val_rm,
  input  logic [DATA_W-1:0] alu_mem_val,
  input  logic [DATA_W-1:0] wb_val,
  input  logic [1:0]        sel_src1,
  input  logic [1:0]        sel_src2,
  input  logic [11:0]       shift_operand,
  input  logic [23:0]       signed_imm_24,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] br_addr,
  output logic [DATA_W-1:0] val_rm_out,
  output logic [3:0]        status,
  output logic              status_we,
  output logic [6:0]        ctl_out
);

  localparam int MUL_ITERS = DATA_W / MUL_BPC;
  localparam int CNT_W     = $clog2(MUL_ITERS + 1);

  exe_state_e state, state_next;

  logic [DATA_W-1:0] op1, rm_f, val2, br_calc, alu_res;
  logic [DATA_W:0]   sum;
  logic [3:0]        alu_flags;
  logic              known_cmd, add_cin, sub_cin;

  logic [CNT_W-1:0]  mul_cnt;
  logic [DATA_W-1:0] mul_acc, mul_mcand, mul_mplier, mul_pp, mul_final;
  logic [6:0]        p_ctl;
  logic              p_sr;
  logic [1:0]        p_cv;
  logic [DATA_W-1:0] p_br, p_rm;

  logic out_free, accept, is_mul, load_alu, mul_start, mul_done;

  always_comb begin
    case (sel_src1)
      FWD_REG:     op1 = val_rn;
      FWD_ALU_MEM: op1 = alu_mem_val;
      FWD_WB:      op1 = wb_val;
      default:     op1 = val_rn;
    endcase
    case (sel_src2)
      FWD_REG:     rm_f = val_rm;
      FWD_ALU_MEM: rm_f = alu_mem_val;
      FWD_WB:      rm_f = wb_val;
      default:     rm_f = val_rm;
    endcase
  end

  val2_gen_p #(.DATA_W(DATA_W)) u_val2_gen (
    .rm            (rm_f),
    .shift_operand (shift_operand),
    .imm           (imm),
    .mem_en        (ctl_in[5] | ctl_in[4]),
    .val2          (val2)
  );

  always_comb begin
    logic signed [DATA_W-1:0] off;
    off     = DATA_W'($signed(signed_imm_24));
    br_calc = pc + DATA_W'(off << 2);
  end

  // SUB/SBC use a + ~b + cin so the carry out is already NOT borrow
  always_comb begin
    add_cin   = (exe_cmd == CMD_ADC) & flags_in[FLAG_C];
    sub_cin   = (exe_cmd == CMD_SUB) | flags_in[FLAG_C];
    sum       = '0;
    alu_res   = '0;
    alu_flags = flags_in;
    known_cmd = 1'b1;
    case (exe_cmd)
      CMD_MOV: alu_res = val2;
      CMD_MVN: alu_res = ~val2;
      CMD_ADD, CMD_ADC: begin
        sum     = {1'b0, op1} + {1'b0, val2} + {{DATA_W{1'b0}}, add_cin};
        alu_res = sum[DATA_W-1:0];
        alu_flags[FLAG_C] = sum[DATA_W];
        alu_flags[FLAG_V] = (op1[DATA_W-1] == val2[DATA_W-1]) & (alu_res[DATA_W-1] != op1[DATA_W-1]);
      end
      CMD_SUB, CMD_SBC: begin
        sum     = {1'b0, op1} + {1'b0, ~val2} + {{DATA_W{1'b0}}, sub_cin};
        alu_res = sum[DATA_W-1:0];
        alu_flags[FLAG_C] = sum[DATA_W];
        alu_flags[FLAG_V] = (op1[DATA_W-1] != val2[DATA_W-1]) & (alu_res[DATA_W-1] != op1[DATA_W-1]);
      end
      CMD_AND: alu_res = op1 & val2;
      CMD_ORR: alu_res = op1 | val2;
      CMD_EOR: alu_res = op1 ^ val2;
      CMD_MUL: alu_res = '0;
      default: known_cmd = 1'b0;
    endcase
    if (known_cmd) begin
      alu_flags[FLAG_N] = alu_res[DATA_W-1];
      alu_flags[FLAG_Z] = (alu_res == '0);
    end
  end

  always_comb begin
    mul_pp = '0;
    for (int j = 0; j < MUL_BPC; j++) begin
      if (mul_mplier[j]) mul_pp = mul_pp + (mul_mcand << j);
    end
    mul_final = mul_acc + mul_pp;
  end

  assign out_free = !out_valid | out_ready;
  assign in_ready = (state == ST_IDLE) & out_free;
  assign accept   = in_valid & in_ready & !flush;
  assign is_mul   = (exe_cmd == CMD_MUL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_alu   = 1'b0;
    mul_start  = 1'b0;
    mul_done   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_mul) begin
            mul_start  = 1'b1;
            state_next = ST_BUSY;
          end else begin
            load_alu = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (mul_cnt == CNT_W'(1) && out_free) begin
          mul_done   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (flush) begin
      state_next = ST_IDLE;
      mul_done   = 1'b0;
    end
  end

  // Multiplier datapath; the last iteration is folded into mul_final so a
  // blocked completion simply holds acc/count until the output frees up.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_cnt    <= '0;
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      p_ctl      <= '0;
      p_sr       <= 1'b0;
      p_cv       <= '0;
      p_br       <= '0;
      p_rm       <= '0;
    end else if (flush) begin
      mul_cnt <= '0;
    end else if (mul_start) begin
      mul_cnt    <= CNT_W'(MUL_ITERS);
      mul_acc    <= '0;
      mul_mcand  <= op1;
      mul_mplier <= val2;
      p_ctl      <= ctl_in;
      p_sr       <= sr;
      p_cv       <= {flags_in[FLAG_C], flags_in[FLAG_V]};
      p_br       <= br_calc;
      p_rm       <= rm_f;
    end else if (state == ST_BUSY) begin
      if (mul_done) begin
        mul_cnt <= '0;
      end else if (mul_cnt != CNT_W'(1)) begin
        mul_acc    <= mul_final;
        mul_mcand  <= mul_mcand << MUL_BPC;
        mul_mplier <= mul_mplier >> MUL_BPC;
        mul_cnt    <= mul_cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      alu_result <= '0;
      br_addr    <= '0;
      val_rm_out <= '0;
      status     <= '0;
      status_we  <= 1'b0;
      ctl_out    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      status_we <= 1'b0;
    end else if (load_alu) begin
      out_valid  <= 1'b1;
      alu_result <= alu_res;
      br_addr    <= br_calc;
      val_rm_out <= rm_f;
      status     <= alu_flags;
      status_we  <= sr;
      ctl_out    <= ctl_in;
    end else if (mul_done) begin
      out_valid  <= 1'b1;
      alu_result <= mul_final;
      br_addr    <= p_br;
      val_rm_out <= p_rm;
      status     <= {mul_final[DATA_W-1], ~|mul_final, p_cv};
      status_we  <= p_sr;
      ctl_out    <= p_ctl;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exe_stage_pipe.sv
// tb/tb_exe_stage_pipe.sv - directed self-checking bench for exe_stage_pipe
module tb_exe_stage_pipe;
  import exe_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, imm, sr, out_valid, out_ready, status_we;
  logic [3:0]  exe_cmd, flags_in, status;
  logic [6:0]  ctl_in, ctl_out;
  logic [31:0] pc, val_rn, val_rm, alu_mem_val, wb_val, alu_result, br_addr, val_rm_out;
  logic [1:0]  sel_src1, sel_src2;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [11:0] shop;
    logic        immv;
    logic [3:0]  flg;
    logic [6:0]  ctl;
    logic [31:0] res;
    logic [3:0]  st;
  } vec_t;

  vec_t vecs [15];

  always #5 clk = ~clk;

  exe_stage_pipe #(.DATA_W(32), .MUL_BPC(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .exe_cmd(exe_cmd), .imm(imm), .sr(sr), .flags_in(flags_in), .ctl_in(ctl_in),
    .pc(pc), .val_rn(val_rn), .val_rm(val_rm), .alu_mem_val(alu_mem_val), .wb_val(wb_val),
    .sel_src1(sel_src1), .sel_src2(sel_src2), .shift_operand(shift_operand),
    .signed_imm_24(signed_imm_24), .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result), .br_addr(br_addr), .val_rm_out(val_rm_out),
    .status(status), .status_we(status_we), .ctl_out(ctl_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                           input logic [11:0] shop, input logic immv, input logic [3:0] flg);
    exe_cmd = cmd; val_rn = rn; val_rm = rm; shift_operand = shop; imm = immv; flags_in = flg;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    checks++;
    if ({out_valid, status_we, status, ctl_out} !== 13'b0) begin
      failures++;
      $display("FAIL reset_ctl: got v=%b we=%b st=%b ctl=%h, expected all 0", out_valid, status_we, status, ctl_out);
    end
    checks++;
    if ({alu_result, br_addr, val_rm_out} !== 96'b0) begin
      failures++;
      $display("FAIL reset_data: got %h %h %h, expected 0", alu_result, br_addr, val_rm_out);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_alu_vectors();
    vecs[0]  = '{CMD_ADD, 32'h7FFFFFFF, 32'h0,        12'h001, 1'b1, 4'b0000, 7'h45, 32'h80000000, 4'b1001};
    vecs[1]  = '{CMD_ADC, 32'hFFFFFFFF, 32'h0,        12'h000, 1'b1, 4'b0010, 7'h45, 32'h00000000, 4'b0110};
    vecs[2]  = '{CMD_SBC, 32'h00000005, 32'h0,        12'h003, 1'b1, 4'b0000, 7'h45, 32'h00000001, 4'b0010};
    vecs[3]  = '{CMD_SUB, 32'h00000000, 32'h0,        12'h001, 1'b1, 4'b0000, 7'h45, 32'hFFFFFFFF, 4'b1000};
    vecs[4]  = '{CMD_SUB, 32'h80000000, 32'h0,        12'h001, 1'b1, 4'b0000, 7'h45, 32'h7FFFFFFF, 4'b0011};
    vecs[5]  = '{CMD_AND, 32'h0000F0F0, 32'h00000FF0, 12'h000, 1'b0, 4'b0011, 7'h45, 32'h000000F0, 4'b0011};
    vecs[6]  = '{CMD_ORR, 32'h0000000F, 32'h0,        12'h4AB, 1'b1, 4'b0000, 7'h45, 32'hAB00000F, 4'b1000};
    vecs[7]  = '{CMD_EOR, 32'hFFFFFFFF, 32'hFFFFFFFF, 12'h000, 1'b0, 4'b0000, 7'h45, 32'h00000000, 4'b0100};
    vecs[8]  = '{CMD_MVN, 32'h0,        32'h0,        12'h000, 1'b1, 4'b0001, 7'h45, 32'hFFFFFFFF, 4'b1001};
    vecs[9]  = '{CMD_MOV, 32'h0,        32'h8000000F, 12'h200, 1'b0, 4'b0000, 7'h45, 32'h000000F0, 4'b0000};
    vecs[10] = '{CMD_MOV, 32'h0,        32'h80000000, 12'h220, 1'b0, 4'b0000, 7'h45, 32'h08000000, 4'b0000};
    vecs[11] = '{CMD_MOV, 32'h0,        32'h80000000, 12'h240, 1'b0, 4'b0000, 7'h45, 32'hF8000000, 4'b1000};
    vecs[12] = '{CMD_MOV, 32'h0,        32'h000000FF, 12'h460, 1'b0, 4'b0000, 7'h45, 32'hFF000000, 4'b1000};
    vecs[13] = '{4'b0000, 32'h5,        32'h0,        12'h000, 1'b0, 4'b1010, 7'h45, 32'h00000000, 4'b1010};
    vecs[14] = '{CMD_ADD, 32'h00000100, 32'h0,        12'hFFF, 1'b0, 4'b0000, 7'h63, 32'h000010FF, 4'b0000};
    out_ready = 1'b1; sr = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      set_instr(vecs[i].cmd, vecs[i].rn, vecs[i].rm, vecs[i].shop, vecs[i].immv, vecs[i].flg);
      ctl_in = vecs[i].ctl;
      step();
      checks++;
      if (out_valid !== 1'b1 || alu_result !== vecs[i].res) begin
        failures++;
        $display("FAIL alu_vec%0d_result: got v=%b %h, expected v=1 %h", i, out_valid, alu_result, vecs[i].res);
      end
      checks++;
      if (status !== vecs[i].st) begin
        failures++;
        $display("FAIL alu_vec%0d_status: got %b, expected %b", i, status, vecs[i].st);
      end
      checks++;
      if ({status_we, ctl_out, val_rm_out} !== {1'b1, vecs[i].ctl, vecs[i].rm}) begin
        failures++;
        $display("FAIL alu_vec%0d_pass: got we=%b ctl=%h rm=%h, expected we=1 ctl=%h rm=%h",
                 i, status_we, ctl_out, val_rm_out, vecs[i].ctl, vecs[i].rm);
      end
    end
    in_valid = 1'b0; ctl_in = 7'h45;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain: got out_valid=%b, expected 0", out_valid);
    end
  endtask

  task automatic test_forwarding();
    set_instr(CMD_SUB, 32'd99, 32'h9, 12'h005, 1'b1, 4'b0000);
    sel_src1 = 2'b01; alu_mem_val = 32'd5; sel_src2 = 2'b10; wb_val = 32'h1234;
    in_valid = 1'b1;
    step();
    checks++;
    if (alu_result !== 32'h0 || status !== 4'b0110) begin
      failures++;
      $display("FAIL fwd_alu_mem: got %h st=%b, expected 00000000 st=0110", alu_result, status);
    end
    checks++;
    if (val_rm_out !== 32'h1234) begin
      failures++;
      $display("FAIL fwd_wb_rm: got %h, expected 00001234", val_rm_out);
    end
    set_instr(CMD_ADD, 32'd7, 32'h9, 12'h001, 1'b1, 4'b0000);
    sel_src1 = 2'b11; sel_src2 = 2'b11;
    step();
    checks++;
    if (alu_result !== 32'd8 || val_rm_out !== 32'h9) begin
      failures++;
      $display("FAIL fwd_sel11: got %h rm=%h, expected 00000008 rm=00000009", alu_result, val_rm_out);
    end
    in_valid = 1'b0; sel_src1 = 2'b00; sel_src2 = 2'b00;
    step();
  endtask

  task automatic test_mul();
    int low = 0;
    int n = 0;
    set_instr(CMD_MUL, 32'h00010003, 32'h0, 12'h007, 1'b1, 4'b0011);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    while (!out_valid && n < 30) begin
      if (!in_ready) low++;
      step();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL mul_timeout: got out_valid=%b after %0d cycles, expected 1", out_valid, n);
    end
    checks++;
    if (low !== 8) begin
      failures++;
      $display("FAIL mul_busy_cycles: got %0d, expected 8", low);
    end
    checks++;
    if (alu_result !== 32'h00070015 || status !== 4'b0011) begin
      failures++;
      $display("FAIL mul_result: got %h st=%b, expected 00070015 st=0011", alu_result, status);
    end
    step();
  endtask

  task automatic test_hold();
    int n = 0;
    out_ready = 1'b0;
    set_instr(CMD_ADD, 32'h1, 32'h0, 12'h001, 1'b1, 4'b0000);
    in_valid = 1'b1;
    step();
    set_instr(CMD_MUL, 32'h1234, 32'h0, 12'h010, 1'b1, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || alu_result !== 32'h2 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_add%0d: got v=%b %h rdy=%b, expected v=1 00000002 rdy=0", i, out_valid, alu_result, in_ready);
      end
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL hold_mul_accept: got v=%b rdy=%b, expected v=0 rdy=0", out_valid, in_ready);
    end
    while (!out_valid && n < 30) begin
      step();
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || alu_result !== 32'h00012340 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_mul%0d: got v=%b %h rdy=%b, expected v=1 00012340 rdy=0", i, out_valid, alu_result, in_ready);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold_drain: got out_valid=%b, expected 0", out_valid);
    end
  endtask

  task automatic test_flush();
    int seen = 0;
    set_instr(CMD_MUL, 32'h5, 32'h0, 12'h005, 1'b1, 4'b0000);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    set_instr(CMD_ADD, 32'h10, 32'h0, 12'h002, 1'b1, 4'b0000);
    in_valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || status_we !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_kill: got v=%b we=%b rdy=%b, expected v=0 we=0 rdy=1", out_valid, status_we, in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || alu_result !== 32'h12) begin
      failures++;
      $display("FAIL flush_next_add: got v=%b %h, expected v=1 00000012", out_valid, alu_result);
    end
    step();
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen++;
      step();
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL flush_no_mul_result: got %0d valid cycles, expected 0", seen);
    end
  endtask

  task automatic test_branch();
    set_instr(CMD_MOV, 32'h0, 32'h000000FF, 12'h460, 1'b0, 4'b0000);
    pc = 32'h100; signed_imm_24 = 24'hFFFFFF;
    in_valid = 1'b1;
    step();
    checks++;
    if (alu_result !== 32'hFF000000 || br_addr !== 32'h000000FC) begin
      failures++;
      $display("FAIL branch_back: got %h br=%h, expected FF000000 br=000000FC", alu_result, br_addr);
    end
    signed_imm_24 = 24'h000010;
    step();
    in_valid = 1'b0;
    checks++;
    if (br_addr !== 32'h00000140) begin
      failures++;
      $display("FAIL branch_fwd: got %h, expected 00000140", br_addr);
    end
    step();
  endtask

  task automatic test_reset_mid_mul();
    int seen = 0;
    set_instr(CMD_MUL, 32'h3, 32'h0, 12'h003, 1'b1, 4'b0000);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    #2;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_mul: got rdy=%b v=%b, expected rdy=1 v=0", in_ready, out_valid);
    end
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL reset_mid_mul_discard: got %0d valid cycles, expected 0", seen);
    end
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sr = 1'b1;
    exe_cmd = '0; imm = 1'b0; flags_in = '0; ctl_in = 7'h45; pc = '0;
    val_rn = '0; val_rm = '0; alu_mem_val = '0; wb_val = '0;
    sel_src1 = 2'b00; sel_src2 = 2'b00; shift_operand = '0; signed_imm_24 = '0;
    test_reset();
    test_alu_vectors();
    test_forwarding();
    test_mul();
    test_hold();
    test_flush();
    test_branch();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
